// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus data-memory port of the load/store controller.
// slave = controller side; master = pipeline/memory environment side.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err, address, write_data, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err, address, write_data, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store controller over a 256-word memory; latency err 1, load/word store 2, sub-word store 3.
// One request in flight: req_ready only in IDLE, so requests wait until the previous response has been given.
module mem_access_ctrl (
  input  logic              clk,
  input  logic              reset_n,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, RMW, WR, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q;
  logic [31:0] old_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        unused_addr_hi;

  // Only addr[9:2] selects a word in the 256-word memory.
  assign unused_addr_hi = ^bus.req_addr[31:10];

  always_comb begin
    case (bus.req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = |bus.req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    case (req_q.addr[1:0])
      2'd0:    lane_b = bus.mem_data_out[7:0];
      2'd1:    lane_b = bus.mem_data_out[15:8];
      2'd2:    lane_b = bus.mem_data_out[23:16];
      default: lane_b = bus.mem_data_out[31:24];
    endcase
    lane_h = req_q.addr[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
    case (req_q.size)
      2'b00:   load_ext = {{24{~req_q.uns & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~req_q.uns & lane_h[15]}}, lane_h};
      default: load_ext = bus.mem_data_out;
    endcase
  end

  always_comb begin
    merged = old_q;
    if (req_q.size == 2'b00) begin
      case (req_q.addr[1:0])
        2'd0:    merged[7:0]   = req_q.wdata[7:0];
        2'd1:    merged[15:8]  = req_q.wdata[7:0];
        2'd2:    merged[23:16] = req_q.wdata[7:0];
        default: merged[31:24] = req_q.wdata[7:0];
      endcase
    end else if (req_q.addr[1]) begin
      merged[31:16] = req_q.wdata[15:0];
    end else begin
      merged[15:0]  = req_q.wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.address    = 32'h0;
    bus.write_data = 32'h0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = resp_rdata_q;
    bus.resp_err   = resp_err_q;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)                   state_nxt = RESP;
          else if (!bus.req_write)       state_nxt = RD;
          else if (bus.req_size == 2'b10) state_nxt = WR;
          else                           state_nxt = RMW;
        end
      end
      RD: begin
        bus.mem_read = 1'b1;
        bus.address  = {24'h0, req_q.addr[9:2]};
        state_nxt    = RESP;
      end
      RMW: begin
        bus.mem_read = 1'b1;
        bus.address  = {24'h0, req_q.addr[9:2]};
        state_nxt    = WR;
      end
      WR: begin
        bus.mem_write  = 1'b1;
        bus.address    = {24'h0, req_q.addr[9:2]};
        bus.write_data = (req_q.size == 2'b10) ? req_q.wdata : merged;
        state_nxt      = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory data is sampled on the edge leaving RD/RMW; memory drives it on the prior negedge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q        <= '0;
      old_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_q <= '{write: bus.req_write, size: bus.req_size, uns: bus.req_unsigned,
                       addr: bus.req_addr[9:0], wdata: bus.req_wdata};
            if (req_err) begin
              resp_rdata_q <= '0;
              resp_err_q   <= 1'b1;
            end
          end
        end
        RD: begin
          resp_rdata_q <= load_ext;
          resp_err_q   <= 1'b0;
        end
        RMW: old_q <= bus.mem_data_out;
        WR: begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, reset/back-to-back sequences, random run vs byte-array model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus();
  mem_access_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [31:0] mem [0:255];
  logic [7:0]  rmem [0:1023];
  int n_vec = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (bus.mem_read)  bus.mem_data_out <= mem[bus.address[7:0]];
    if (bus.mem_write) mem[bus.address[7:0]] <= bus.write_data;
  end

  always @(negedge clk) begin
    if (reset_n && bus.mem_read && bus.mem_write) begin
      n_err++;
      $display("FAIL rd_wr_overlap: mem_read=1 mem_write=1 at %0t, required never both", $time);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat,
                      output int n_rd, output int n_wr,
                      output logic [31:0] st_addr, output logic [31:0] st_wdata);
    int guard;
    @(negedge clk);
    bus.req_write = w; bus.req_size = sz; bus.req_unsigned = u;
    bus.req_addr = a;  bus.req_wdata = wd; bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; n_rd = 0; n_wr = 0; st_addr = 32'hx; st_wdata = 32'hx;
    while (!bus.resp_valid && lat < 8) begin
      if (bus.mem_read)  begin n_rd++; st_addr = bus.address; end
      if (bus.mem_write) begin n_wr++; st_addr = bus.address; st_wdata = bus.write_data; end
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    @(posedge clk); #1;
    check("resp_one_cycle", {31'b0, bus.resp_valid}, 32'd0);
  endtask

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd, st_addr, st_wdata, ev;
    logic        er;
    int          lat, n_rd, n_wr, nb, ex_rd, ex_wr, ex_lat;
    logic        w, u, e;
    logic [1:0]  sz;
    logic [31:0] a, wd;

    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h14,       32'h0,        32'h8765_4321, 1'b0, 2, 32'h0};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h17,       32'h0,        32'hFFFF_FF87, 1'b0, 2, 32'h0};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h17,       32'h0,        32'h0000_0087, 1'b0, 2, 32'h0};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h14,       32'h0,        32'h0000_0021, 1'b0, 2, 32'h0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h16,       32'h0,        32'h0000_0065, 1'b0, 2, 32'h0};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h16,       32'h0,        32'hFFFF_8765, 1'b0, 2, 32'h0};
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h0E,       32'h0000_ABCD, 32'h0,        1'b0, 3, 32'hABCD_3344};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0C,       32'h0,        32'hABCD_3344, 1'b0, 2, 32'h0};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h02,       32'h0,        32'h0,         1'b1, 1, 32'h0};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h01,       32'h0,        32'h0,         1'b1, 1, 32'h0};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h00,       32'h0,        32'h0,         1'b1, 1, 32'h0};
    vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h20,       32'hDEAD_BEEF, 32'h0,        1'b0, 2, 32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 2'b01, 1'b0, 32'h22,       32'h0,        32'hFFFF_DEAD, 1'b0, 2, 32'h0};
    vecs[13] = '{1'b0, 2'b01, 1'b1, 32'h20,       32'h0,        32'h0000_BEEF, 1'b0, 2, 32'h0};
    vecs[14] = '{1'b1, 2'b00, 1'b0, 32'h21,       32'hFFFF_FF55, 32'h0,        1'b0, 3, 32'hDEAD_55EF};
    vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h20,       32'h0,        32'hDEAD_55EF, 1'b0, 2, 32'h0};
    vecs[16] = '{1'b1, 2'b01, 1'b0, 32'h23,       32'h0000_1234, 32'h0,        1'b1, 1, 32'h0};
    vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h20,       32'h0,        32'hDEAD_55EF, 1'b0, 2, 32'h0};
    vecs[18] = '{1'b0, 2'b10, 1'b0, 32'hFFFF_FC14, 32'h0,        32'h8765_4321, 1'b0, 2, 32'h0};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[5] = 32'h8765_4321;
    mem[3] = 32'h1122_3344;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    // Reset state
    #12;
    check("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
    check("rst_resp_rdata", bus.resp_rdata,          32'd0);
    check("rst_mem_read",   {31'b0, bus.mem_read},   32'd0);
    check("rst_mem_write",  {31'b0, bus.mem_write},  32'd0);
    check("rst_address",    bus.address,             32'd0);
    check("rst_write_data", bus.write_data,          32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      xact(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, rd, er, lat, n_rd, n_wr, st_addr, st_wdata);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      ex_rd = vecs[i].exp_err ? 0 : (!vecs[i].w || vecs[i].sz != 2'b10) ? 1 : 0;
      ex_wr = (vecs[i].exp_err || !vecs[i].w) ? 0 : 1;
      check($sformatf("v%0d_read_cycles", i), n_rd, ex_rd);
      check($sformatf("v%0d_write_cycles", i), n_wr, ex_wr);
      if (!vecs[i].exp_err) check($sformatf("v%0d_address", i), st_addr, {24'h0, vecs[i].a[9:2]});
      if (!vecs[i].exp_err && vecs[i].w) check($sformatf("v%0d_write_data", i), st_wdata, vecs[i].exp_wdata);
    end

    // Reset while in RD: strobe drops without a clock edge, no response follows
    @(negedge clk);
    bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h14; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rstmid_in_rd", {31'b0, bus.mem_read}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_mem_read",  {31'b0, bus.mem_read},  32'd0);
    check("rstmid_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rstmid_address",   bus.address,            32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstmid_no_resp", {31'b0, bus.resp_valid}, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rstmid_ready_after", {31'b0, bus.req_ready}, 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat, n_rd, n_wr, st_addr, st_wdata);
    check("rstmid_reload_rdata", rd, 32'h8765_4321);
    check("rstmid_reload_lat", lat, 2);

    // Back-to-back with req_valid held: store then load
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h40; bus.req_wdata = 32'h1234_5678; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_store_wr", {31'b0, bus.mem_write}, 32'd1);
    bus.req_write = 1'b0;
    @(posedge clk); #1;
    check("b2b_store_resp", {31'b0, bus.resp_valid}, 32'd1);
    check("b2b_busy_ready", {31'b0, bus.req_ready},  32'd0);
    @(posedge clk); #1;
    check("b2b_idle_ready", {31'b0, bus.req_ready},  32'd1);
    check("b2b_idle_read",  {31'b0, bus.mem_read},   32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("b2b_load_rd",    {31'b0, bus.mem_read},   32'd1);
    check("b2b_load_addr",  bus.address,             32'h10);
    @(posedge clk); #1;
    check("b2b_load_resp",  {31'b0, bus.resp_valid}, 32'd1);
    check("b2b_load_rdata", bus.resp_rdata,          32'h1234_5678);
    @(posedge clk); #1;

    // Random run against a byte-addressed model
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      for (int k = 0; k < 4; k++) rmem[4*i+k] = mem[i][8*k +: 8];
    end
    for (int t = 0; t < 300; t++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom;
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      e  = ref_err(sz, a);
      nb = 1 << sz;
      ev = 32'h0;
      if (e) begin
        ex_lat = 1;
      end else if (!w) begin
        for (int k = 0; k < nb; k++) ev = ev | ({24'h0, rmem[int'(a[9:0]) + k]} << (8 * k));
        if (!u && nb < 4 && ev[8*nb-1]) ev = ev | (32'hFFFF_FFFF << (8 * nb));
        ex_lat = 2;
      end else begin
        for (int k = 0; k < nb; k++) rmem[int'(a[9:0]) + k] = 8'(wd >> (8 * k));
        ex_lat = (nb == 4) ? 2 : 3;
      end
      xact(w, sz, u, a, wd, rd, er, lat, n_rd, n_wr, st_addr, st_wdata);
      check($sformatf("rnd%0d_rdata", t), rd, ev);
      check($sformatf("rnd%0d_err", t), {31'b0, er}, {31'b0, e});
      check($sformatf("rnd%0d_latency", t), lat, ex_lat);
    end

    // Final sweep: DUT-side memory must match the model byte for byte
    for (int i = 0; i < 256; i++) begin
      ev = {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]};
      if (mem[i] !== ev) check($sformatf("mem_word%0d", i), mem[i], ev);
    end
    check("mem_sweep_word0", mem[0], {rmem[3], rmem[2], rmem[1], rmem[0]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
